// File: rtl/prefetch_unit.sv
// Decoupled instruction prefetch unit: fills a DEPTH-entry queue from a req/ack
// fetch bus and presents the registered queue head to decode.
module prefetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              little_endian_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_error,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_error,
  input  logic              instr_ready
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));
  localparam logic [CNT_W-1:0]  FULL       = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   rptr, wptr;
  logic [CNT_W-1:0]   count;

  logic [DATA_W-1:0]  q_data [DEPTH];
  logic [ADDR_W-1:0]  q_pc   [DEPTH];
  logic [DEPTH-1:0]   q_err;

  logic               acked, push, pop, head_from_push;
  logic [DATA_W-1:0]  push_data;
  logic [PTR_W-1:0]   rptr_n;
  logic [CNT_W-1:0]   count_n;
  logic [DATA_W-1:0]  head_data_n;
  logic [ADDR_W-1:0]  head_pc_n;
  logic               head_err_n;
  logic [ADDR_W-1:0]  flush_pc_al;
  logic [ADDR_W-1:0]  next_pc;

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      r[8*(BYTES-1-i) +: 8] = w[8*i +: 8];
    end
    return r;
  endfunction

  // Queue bookkeeping and next head contents
  always_comb begin
    acked          = mem_req & mem_ack;
    push           = acked & (state == FETCH) & ~flush;
    pop            = instr_valid & instr_ready;
    push_data      = mem_error ? '0 : (little_endian_en ? byte_rev(mem_rdata) : mem_rdata);
    rptr_n         = pop ? rptr + PTR_W'(1) : rptr;
    count_n        = count + CNT_W'(push) - CNT_W'(pop);
    // Pushed word becomes the head only when nothing older remains after the pop
    head_from_push = push & (wptr == rptr_n);
    head_data_n    = head_from_push ? push_data : q_data[rptr_n];
    head_pc_n      = head_from_push ? fetch_pc  : q_pc[rptr_n];
    head_err_n     = head_from_push ? mem_error : q_err[rptr_n];
    flush_pc_al    = flush_pc & ALIGN_MASK;
    next_pc        = fetch_pc + STEP;
  end

  // Queue storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wptr] <= push_data;
      q_pc[wptr]   <= fetch_pc;
      q_err[wptr]  <= mem_error;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_error <= 1'b0;
    end else begin
      if (flush) begin
        rptr        <= '0;
        wptr        <= '0;
        count       <= '0;
        instr_valid <= 1'b0;
      end else begin
        rptr        <= rptr_n;
        if (push) wptr <= wptr + PTR_W'(1);
        count       <= count_n;
        instr_valid <= (count_n != '0);
        instr       <= head_data_n;
        instr_pc    <= head_pc_n;
        instr_error <= head_err_n;
      end

      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b0;
          if (flush) begin
            fetch_pc <= flush_pc_al;
            mem_addr <= flush_pc_al;
          end
        end
        FETCH: begin
          if (flush) begin
            fetch_pc <= flush_pc_al;
            // An unacked request must complete at its old address before redirecting
            if (mem_req && !mem_ack) begin
              state <= DRAIN;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= flush_pc_al;
            end
          end else if (acked && mem_error) begin
            state   <= HALT;
            mem_req <= 1'b0;
          end else if (acked) begin
            fetch_pc <= next_pc;
            mem_addr <= next_pc;
            mem_req  <= (count_n < FULL);
          end else if (!mem_req) begin
            mem_req  <= (count_n < FULL);
            mem_addr <= fetch_pc;
          end
        end
        DRAIN: begin
          if (flush) fetch_pc <= flush_pc_al;
          if (acked) begin
            state    <= FETCH;
            mem_req  <= 1'b0;
            mem_addr <= flush ? flush_pc_al : fetch_pc;
          end
        end
        HALT: begin
          mem_req <= 1'b0;
          if (flush) begin
            state    <= FETCH;
            fetch_pc <= flush_pc_al;
            mem_addr <= flush_pc_al;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: cycle-vector table plus hand-written
// endianness, flush, error and reset sequences.
module tb_prefetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              little_endian_en = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] flush_pc = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_error = 1'b0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_error;
  logic              instr_ready = 1'b0;

  logic              rmode = 1'b0;
  logic [DATA_W-1:0] fixed_word = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns its own address unless a fixed word is selected
  assign mem_rdata = rmode ? fixed_word : mem_addr;

  prefetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .little_endian_en(little_endian_en),
    .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_error(mem_error),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_error(instr_error), .instr_ready(instr_ready)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ack;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic rd, input logic a, input logic v,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input logic rq, input logic [31:0] ad);
    vec_t e;
    e.rst = r; e.rdy = rd; e.ack = a; e.v = v;
    e.pc = pc; e.ins = ins; e.req = rq; e.addr = ad;
    vecs.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_error = 1'b0;
    instr_ready = 1'b0; little_endian_en = 1'b0; rmode = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit found;

    // rst rdy ack | valid pc instr req addr
    add(1, 1, 1, 0, 32'h0,  32'h0,  0, 32'h0);
    add(0, 1, 1, 0, 32'h0,  32'h0,  0, 32'h0);
    add(0, 1, 1, 0, 32'h0,  32'h0,  1, 32'h0);
    add(0, 1, 1, 1, 32'h0,  32'h0,  1, 32'h4);
    add(0, 1, 1, 1, 32'h4,  32'h4,  1, 32'h8);
    add(0, 1, 1, 1, 32'h8,  32'h8,  1, 32'hC);
    add(0, 1, 1, 1, 32'hC,  32'hC,  1, 32'h10);
    add(1, 0, 1, 0, 32'h0,  32'h0,  0, 32'h0);
    add(0, 0, 1, 0, 32'h0,  32'h0,  0, 32'h0);
    add(0, 0, 1, 0, 32'h0,  32'h0,  1, 32'h0);
    add(0, 0, 1, 1, 32'h0,  32'h0,  1, 32'h4);
    add(0, 0, 1, 1, 32'h0,  32'h0,  1, 32'h8);
    add(0, 0, 1, 1, 32'h0,  32'h0,  1, 32'hC);
    add(0, 0, 1, 1, 32'h0,  32'h0,  0, 32'h10);
    add(0, 0, 1, 1, 32'h0,  32'h0,  0, 32'h10);
    add(0, 1, 1, 1, 32'h4,  32'h4,  1, 32'h10);
    add(0, 0, 0, 1, 32'h4,  32'h4,  1, 32'h10);
    add(0, 0, 1, 1, 32'h4,  32'h4,  0, 32'h14);

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      instr_ready = vecs[i].rdy;
      mem_ack = vecs[i].ack;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d_req", i),   32'(mem_req),     32'(vecs[i].req));
      check($sformatf("vec%0d_addr", i),  mem_addr,         vecs[i].addr);
      check($sformatf("vec%0d_err", i),   32'(instr_error), 32'h0);
      if (vecs[i].v || vecs[i].rst) begin
        check($sformatf("vec%0d_pc", i),    instr_pc, vecs[i].pc);
        check($sformatf("vec%0d_instr", i), instr,    vecs[i].ins);
      end
    end

    // Byte-lane reversal, sampled per acknowledged word
    do_reset();
    rmode = 1'b1; fixed_word = 32'h11223344; little_endian_en = 1'b1; mem_ack = 1'b1;
    tick(); tick(); tick();
    check("le_valid", 32'(instr_valid), 32'h1);
    check("le_swap", instr, 32'h44332211);
    little_endian_en = 1'b0;
    tick();
    mem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    check("le_pass", instr, 32'h11223344);
    check("le_pass_pc", instr_pc, 32'h4);

    // Flush while a request at 0x8 waits for a delayed ack
    do_reset();
    instr_ready = 1'b1; mem_ack = 1'b1;
    tick(); tick(); tick(); tick();
    mem_ack = 1'b0;
    tick();
    check("fl_req_pending", 32'(mem_req), 32'h1);
    check("fl_addr_pending", mem_addr, 32'h8);
    flush = 1'b1; flush_pc = 32'h103;
    tick();
    flush = 1'b0;
    check("fl_valid_cleared", 32'(instr_valid), 32'h0);
    check("fl_req_held", 32'(mem_req), 32'h1);
    check("fl_addr_held", mem_addr, 32'h8);
    tick();
    check("fl_addr_held2", mem_addr, 32'h8);
    mem_ack = 1'b1;
    tick();
    check("fl_drop_valid", 32'(instr_valid), 32'h0);
    check("fl_drop_req", 32'(mem_req), 32'h0);
    tick();
    check("fl_new_req", 32'(mem_req), 32'h1);
    check("fl_new_addr", mem_addr, 32'h100);
    tick();
    check("fl_first_valid", 32'(instr_valid), 32'h1);
    check("fl_first_pc", instr_pc, 32'h100);
    check("fl_first_instr", instr, 32'h100);

    // Bus error at 0xC halts fetching until a flush
    do_reset();
    mem_ack = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("er_addr", mem_addr, 32'hC);
    mem_error = 1'b1;
    tick();
    mem_error = 1'b0;
    check("er_req_off", 32'(mem_req), 32'h0);
    instr_ready = 1'b1;
    tick(); tick(); tick();
    instr_ready = 1'b0;
    check("er_head_err", 32'(instr_error), 32'h1);
    check("er_head_pc", instr_pc, 32'hC);
    check("er_head_instr", instr, 32'h0);
    tick(); tick();
    check("er_halted", 32'(mem_req), 32'h0);
    flush = 1'b1; flush_pc = 32'h40; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    check("er_flush_valid", 32'(instr_valid), 32'h0);
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      if (mem_req) found = 1'b1;
      else tick();
    end
    check("er_resume_req", 32'(found), 32'h1);
    check("er_resume_addr", mem_addr, 32'h40);
    tick();
    check("er_resume_valid", 32'(instr_valid), 32'h1);
    check("er_resume_pc", instr_pc, 32'h40);
    check("er_resume_err", 32'(instr_error), 32'h0);

    // Asynchronous reset with three queued entries and a pending request
    do_reset();
    mem_ack = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    mem_ack = 1'b0;
    tick();
    check("rs_pre_valid", 32'(instr_valid), 32'h1);
    check("rs_pre_req", 32'(mem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid", 32'(instr_valid), 32'h0);
    check("rs_req", 32'(mem_req), 32'h0);
    check("rs_addr", mem_addr, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rs_e1_req", 32'(mem_req), 32'h0);
    tick();
    check("rs_e2_req", 32'(mem_req), 32'h1);
    check("rs_e2_addr", mem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
